snitch_data_mem_pg: RTL and testbench

SNITCH_DATA_MEM_PG -- requirements
Module: snitch_data_mem_pg

---
 rtl/snitch_data_mem_pg_pkg.sv | 15 +
 rtl/snitch_data_mem_pg_bank_ctrl.sv | 108 ++++++++++
 rtl/tc_sram_impl.sv | 34 +++
 rtl/snitch_data_mem_pg.sv | 68 ++++++
 tb/tb_snitch_data_mem_pg.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snitch_data_mem_pg_pkg.sv
// Shared types and helpers for the power-gated TCDM bank array.
package snitch_data_mem_pg_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        SLEEP  = 2'd1,
        WAKE   = 2'd2
    } bank_state_e;

    // Width of a counter that must hold every value 0..threshold.
    function automatic int cnt_width(input int threshold);
        return (threshold < 2) ? 1 : $clog2(threshold + 1);
    endfunction

endpackage

// File: rtl/snitch_data_mem_pg_bank_ctrl.sv
// One bank's power FSM (ACTIVE/SLEEP/WAKE), idle/wake counters and read-valid pipeline.
module snitch_data_mem_pg_bank_ctrl
    import snitch_data_mem_pg_pkg::*;
#(
    parameter int DataWidth     = 64,
    parameter int ReadLatency   = 1,
    parameter int WakeCycles    = 4,
    parameter int IdleThreshold = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic                 sleep_req_i,
    input  logic [DataWidth-1:0] sram_rdata_i,
    output logic                 gnt_o,
    output logic                 awake_o,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o
);

    localparam int IdleW = cnt_width(IdleThreshold);
    localparam int WakeW = cnt_width(WakeCycles);
    localparam logic [IdleW-1:0] IdleMax  = IdleW'(IdleThreshold);
    localparam logic [WakeW-1:0] WakeLast = WakeW'(WakeCycles - 1);

    bank_state_e            state_reg, state_next;
    logic [IdleW-1:0]       idle_cnt_reg, idle_cnt_next;
    logic [WakeW-1:0]       wake_cnt_reg, wake_cnt_next;
    logic [ReadLatency-1:0] vld_reg;
    logic [DataWidth-1:0]   rdata_pipe;
    logic                   read_inflight;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= ACTIVE;
            idle_cnt_reg <= '0;
            wake_cnt_reg <= '0;
            vld_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            idle_cnt_reg <= idle_cnt_next;
            wake_cnt_reg <= wake_cnt_next;
            vld_reg      <= (vld_reg << 1) | ReadLatency'(gnt_o && !we_i);
        end
    end

    // The SRAM supplies the first stage; extra latency is added with plain data registers.
    generate
        if (ReadLatency == 1) begin : g_lat1
            assign rdata_pipe    = sram_rdata_i;
            assign read_inflight = 1'b0;
        end else begin : g_latn
            logic [DataWidth-1:0] data_reg [ReadLatency-1];
            always_ff @(posedge clk_i) begin
                data_reg[0] <= sram_rdata_i;
                for (int s = 1; s < ReadLatency - 1; s++) begin
                    data_reg[s] <= data_reg[s-1];
                end
            end
            assign rdata_pipe    = data_reg[ReadLatency-2];
            // The output stage is delivered this cycle, so only earlier stages hold off sleep.
            assign read_inflight = |vld_reg[ReadLatency-2:0];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        idle_cnt_next = idle_cnt_reg;
        wake_cnt_next = wake_cnt_reg;
        gnt_o         = 1'b0;
        unique case (state_reg)
            ACTIVE: begin
                gnt_o = req_i;
                if (req_i) begin
                    idle_cnt_next = '0;
                end else if (idle_cnt_reg != IdleMax) begin
                    idle_cnt_next = idle_cnt_reg + 1'b1;
                end
                if (!req_i && !read_inflight &&
                    (sleep_req_i || (IdleThreshold > 0 && idle_cnt_reg == IdleMax))) begin
                    state_next = SLEEP;
                end
            end
            SLEEP: begin
                if (req_i && !sleep_req_i) begin
                    state_next    = WAKE;
                    wake_cnt_next = '0;
                end
            end
            WAKE: begin
                if (wake_cnt_reg == WakeLast) begin
                    state_next    = ACTIVE;
                    idle_cnt_next = '0;
                    wake_cnt_next = '0;
                end else begin
                    wake_cnt_next = wake_cnt_reg + 1'b1;
                end
            end
            default: state_next = ACTIVE;
        endcase
    end

    assign awake_o  = (state_reg == ACTIVE);
    assign rvalid_o = vld_reg[ReadLatency-1];
    assign rdata_o  = rvalid_o ? rdata_pipe : '0;

endmodule

// File: rtl/tc_sram_impl.sv
// Single-port SRAM with byte enables and one registered read stage.
module tc_sram_impl #(
    parameter int NumWords  = 1024,
    parameter int DataWidth = 64,
    parameter int AddrWidth = $clog2(NumWords)
) (
    input  logic                   clk_i,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] be_i,
    output logic [DataWidth-1:0]   rdata_o
);

    logic [DataWidth-1:0] mem_reg [NumWords];
    logic [DataWidth-1:0] rdata_reg;

    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            for (int b = 0; b < DataWidth / 8; b++) begin
                if (be_i[b]) begin
                    mem_reg[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        if (req_i && !we_i) begin
            rdata_reg <= mem_reg[addr_i];
        end
    end

    assign rdata_o = rdata_reg;

endmodule

// File: rtl/snitch_data_mem_pg.sv
// Multi-bank TCDM with per-bank power gating; banks are fully independent.
module snitch_data_mem_pg
    import snitch_data_mem_pg_pkg::*;
#(
    parameter int TCDMDepth     = 1024,
    parameter int DataWidth     = 64,
    parameter int NumBanks      = 32,
    parameter int ReadLatency   = 1,
    parameter int WakeCycles    = 4,
    parameter int IdleThreshold = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumBanks-1:0]                  mem_req_i,
    output logic [NumBanks-1:0]                  mem_gnt_o,
    input  logic [NumBanks-1:0]                  mem_we_i,
    input  logic [NumBanks*$clog2(TCDMDepth)-1:0] mem_addr_i,
    input  logic [NumBanks*DataWidth/8-1:0]      mem_be_i,
    input  logic [NumBanks*DataWidth-1:0]        mem_wdata_i,
    output logic [NumBanks-1:0]                  mem_rvalid_o,
    output logic [NumBanks*DataWidth-1:0]        mem_rdata_o,
    input  logic [NumBanks-1:0]                  bank_sleep_req_i,
    output logic [NumBanks-1:0]                  bank_awake_o
);

    localparam int AddrWidth = $clog2(TCDMDepth);
    localparam int BeWidth   = DataWidth / 8;

    generate
        for (genvar gi = 0; gi < NumBanks; gi++) begin : g_bank
            logic [DataWidth-1:0] sram_rdata;

            snitch_data_mem_pg_bank_ctrl #(
                .DataWidth     (DataWidth),
                .ReadLatency   (ReadLatency),
                .WakeCycles    (WakeCycles),
                .IdleThreshold (IdleThreshold)
            ) i_ctrl (
                .clk_i        (clk_i),
                .rst_i        (rst_i),
                .req_i        (mem_req_i[gi]),
                .we_i         (mem_we_i[gi]),
                .sleep_req_i  (bank_sleep_req_i[gi]),
                .sram_rdata_i (sram_rdata),
                .gnt_o        (mem_gnt_o[gi]),
                .awake_o      (bank_awake_o[gi]),
                .rvalid_o     (mem_rvalid_o[gi]),
                .rdata_o      (mem_rdata_o[gi*DataWidth +: DataWidth])
            );

            // Only granted requests reach the array, so a sleeping bank is never accessed.
            tc_sram_impl #(
                .NumWords  (TCDMDepth),
                .DataWidth (DataWidth),
                .AddrWidth (AddrWidth)
            ) i_sram (
                .clk_i   (clk_i),
                .req_i   (mem_gnt_o[gi]),
                .we_i    (mem_we_i[gi]),
                .addr_i  (mem_addr_i[gi*AddrWidth +: AddrWidth]),
                .wdata_i (mem_wdata_i[gi*DataWidth +: DataWidth]),
                .be_i    (mem_be_i[gi*BeWidth +: BeWidth]),
                .rdata_o (sram_rdata)
            );
        end
    endgenerate

endmodule

// File: tb/tb_snitch_data_mem_pg.sv
// Directed and randomized checks of the power-gated TCDM at ReadLatency=2.
module tb_snitch_data_mem_pg;

    localparam int NB    = 32;
    localparam int DW    = 64;
    localparam int BW    = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic clk = 1'b0;
    logic rst;
    logic [NB-1:0]    req, we, sleep_req, gnt, rvalid, awake;
    logic [NB*AW-1:0] addr_v;
    logic [NB*BW-1:0] be_v;
    logic [NB*DW-1:0] wdata_v, rdata_v;
    logic [AW-1:0]    addr  [NB];
    logic [BW-1:0]    be    [NB];
    logic [DW-1:0]    wdata [NB];

    int checks = 0;
    int errors = 0;
    int lat;

    logic [DW-1:0] model_mem [NB][8];
    logic [1:0]    exp_v  [NB];
    logic [DW-1:0] exp_d0 [NB];
    logic [DW-1:0] exp_d1 [NB];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NB; gi++) begin : g_pack
        assign addr_v[gi*AW +: AW]  = addr[gi];
        assign be_v[gi*BW +: BW]    = be[gi];
        assign wdata_v[gi*DW +: DW] = wdata[gi];
    end

    snitch_data_mem_pg #(
        .TCDMDepth     (DEPTH),
        .DataWidth     (DW),
        .NumBanks      (NB),
        .ReadLatency   (2),
        .WakeCycles    (4),
        .IdleThreshold (16)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .mem_req_i        (req),
        .mem_gnt_o        (gnt),
        .mem_we_i         (we),
        .mem_addr_i       (addr_v),
        .mem_be_i         (be_v),
        .mem_wdata_i      (wdata_v),
        .mem_rvalid_o     (rvalid),
        .mem_rdata_o      (rdata_v),
        .bank_sleep_req_i (sleep_req),
        .bank_awake_o     (awake)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        req = '0; we = '0; sleep_req = '0;
        for (int b = 0; b < NB; b++) begin
            addr[b] = '0; be[b] = '0; wdata[b] = '0;
        end
    endtask

    task automatic drv(input int b, input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [BW-1:0] e, input logic [DW-1:0] d);
        req[b] = r; we[b] = w; addr[b] = a; be[b] = e; wdata[b] = d;
        $display("txn bank=%0d req=%b we=%b addr=%0d be=%h wdata=%h", b, r, w, a, e, d);
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Hold a read on bank 0 until granted; sleep_req is raised after the first cycle to show WAKE ignores it.
    task automatic wait_grant(input logic [AW-1:0] a, output int cycles);
        logic got;
        got = 1'b0;
        cycles = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            drv(0, 1'b1, 1'b0, a, 8'h00, 64'h0);
            sleep_req[0] = (k >= 1);
            mid();
            if (gnt[0]) begin
                got = 1'b1;
            end else begin
                cycles++;
                nxt();
            end
        end
    endtask

    task automatic rnd_cycle(input int mode, input int k);
        logic [NB-1:0] exp_gnt;
        for (int b = 0; b < NB; b++) begin
            if (mode == 0) begin
                req[b] = 1'b1; we[b] = 1'b1; addr[b] = AW'(k); be[b] = '1;
                wdata[b] = {$urandom, $urandom};
            end else if (mode == 1) begin
                req[b]   = ($urandom_range(0, 1) == 1) || ((k % 8) == (b % 8));
                we[b]    = ($urandom_range(0, 1) == 1);
                addr[b]  = AW'($urandom_range(0, 7));
                be[b]    = BW'($urandom);
                wdata[b] = {$urandom, $urandom};
            end else begin
                req[b] = 1'b0; we[b] = 1'b0;
            end
        end
        exp_gnt = req;
        $display("rnd cycle=%0d mode=%0d req=%h we=%h", k, mode, req, we);
        mid();
        chk("rnd_gnt", DW'(gnt), DW'(exp_gnt));
        for (int b = 0; b < NB; b++) begin
            chk1($sformatf("rnd_rvalid[%0d]", b), rvalid[b], exp_v[b][1]);
            chk($sformatf("rnd_rdata[%0d]", b), rdata_v[b*DW +: DW], exp_v[b][1] ? exp_d1[b] : '0);
        end
        for (int b = 0; b < NB; b++) begin
            exp_v[b][1] = exp_v[b][0];
            exp_d1[b]   = exp_d0[b];
            exp_v[b][0] = req[b] && !we[b];
            exp_d0[b]   = model_mem[b][addr[b][2:0]];
            if (req[b] && we[b]) begin
                for (int y = 0; y < BW; y++) begin
                    if (be[b][y]) model_mem[b][addr[b][2:0]][y*8 +: 8] = wdata[b][y*8 +: 8];
                end
            end
        end
        nxt();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        nxt();
        drv(0, 1'b1, 1'b0, 6'd0, 8'h00, 64'h0);
        mid();
        chk1("rst_gnt_follows_req", gnt[0], 1'b1);
        nxt();
        rst = 1'b0;
        clear_inputs();

        // Full write then read at latency 2
        drv(0, 1'b1, 1'b1, 6'd5, 8'hFF, 64'hDEADBEEF_01234567);
        mid();
        chk("rst_awake_all", DW'(awake), DW'({NB{1'b1}}));
        chk1("rst_rvalid", rvalid[0], 1'b0);
        chk("rst_rdata", rdata_v[DW-1:0], 64'h0);
        chk1("write_gnt", gnt[0], 1'b1);
        nxt();
        drv(0, 1'b1, 1'b0, 6'd5, 8'h00, 64'h0);
        mid();
        chk1("read_gnt", gnt[0], 1'b1);
        chk1("write_no_rvalid", rvalid[0], 1'b0);
        nxt();
        clear_inputs();
        mid();
        chk1("lat1_rvalid", rvalid[0], 1'b0);
        chk("lat1_rdata_zero", rdata_v[DW-1:0], 64'h0);
        nxt();
        mid();
        chk1("lat2_rvalid", rvalid[0], 1'b1);
        chk("lat2_rdata", rdata_v[DW-1:0], 64'hDEADBEEF_01234567);
        nxt();

        // Partial write, then back-to-back reads
        drv(0, 1'b1, 1'b1, 6'd9, 8'hFF, 64'h0);
        mid();
        chk1("rvalid_single_pulse", rvalid[0], 1'b0);
        nxt();
        drv(0, 1'b1, 1'b1, 6'd9, 8'h0F, 64'hFFFFFFFF_FFFFFFFF);
        nxt();
        drv(0, 1'b1, 1'b0, 6'd9, 8'h00, 64'h0);
        nxt();
        drv(0, 1'b1, 1'b0, 6'd5, 8'h00, 64'h0);
        mid();
        chk1("b2b_gnt", gnt[0], 1'b1);
        nxt();
        clear_inputs();
        mid();
        chk1("partial_rvalid", rvalid[0], 1'b1);
        chk("partial_rdata", rdata_v[DW-1:0], 64'h00000000_FFFFFFFF);
        nxt();
        mid();
        chk1("b2b_rvalid", rvalid[0], 1'b1);
        chk("b2b_rdata", rdata_v[DW-1:0], 64'hDEADBEEF_01234567);
        nxt();
        mid();
        chk1("b2b_done", rvalid[0], 1'b0);
        nxt();

        // Sleep request colliding with a read
        drv(0, 1'b1, 1'b0, 6'd5, 8'h00, 64'h0);
        sleep_req[0] = 1'b1;
        mid();
        chk1("collide_gnt", gnt[0], 1'b1);
        nxt();
        req[0] = 1'b0;
        mid();
        chk1("collide_awake_inflight", awake[0], 1'b1);
        nxt();
        mid();
        chk1("collide_rvalid", rvalid[0], 1'b1);
        chk("collide_rdata", rdata_v[DW-1:0], 64'hDEADBEEF_01234567);
        chk1("collide_awake_drain", awake[0], 1'b1);
        nxt();
        drv(0, 1'b1, 1'b0, 6'd5, 8'h00, 64'h0);
        mid();
        chk1("sleep_entered", awake[0], 1'b0);
        chk1("sleep_no_gnt", gnt[0], 1'b0);
        nxt();
        mid();
        chk1("sleep_held_no_gnt", gnt[0], 1'b0);
        nxt();

        // Wake from forced sleep
        sleep_req[0] = 1'b0;
        wait_grant(6'd5, lat);
        chk("wake_latency", DW'(lat), DW'(5));
        chk1("wake_awake", awake[0], 1'b1);
        nxt();
        clear_inputs();
        mid();
        chk1("wake_read_lat1", rvalid[0], 1'b0);
        nxt();
        mid();
        chk1("retain_rvalid", rvalid[0], 1'b1);
        chk("retain_rdata", rdata_v[DW-1:0], 64'hDEADBEEF_01234567);
        nxt();

        // Auto-sleep after the idle counter reaches 16
        repeat (14) nxt();
        mid();
        chk1("idle_awake_before", awake[0], 1'b1);
        nxt();
        mid();
        chk1("idle_autosleep", awake[0], 1'b0);
        nxt();
        wait_grant(6'd9, lat);
        chk("autowake_latency", DW'(lat), DW'(5));
        nxt();
        clear_inputs();
        mid();
        chk1("autowake_lat1", rvalid[0], 1'b0);
        nxt();
        mid();
        chk1("autowake_rvalid", rvalid[0], 1'b1);
        chk("autowake_rdata", rdata_v[DW-1:0], 64'h00000000_FFFFFFFF);
        nxt();

        // Reset with two reads in flight on bank 0 and bank 1 in WAKE
        drv(0, 1'b1, 1'b0, 6'd5, 8'h00, 64'h0);
        drv(1, 1'b1, 1'b0, 6'd0, 8'h00, 64'h0);
        mid();
        chk1("rstmid_gnt0", gnt[0], 1'b1);
        chk1("rstmid_gnt1_asleep", gnt[1], 1'b0);
        nxt();
        drv(0, 1'b1, 1'b0, 6'd9, 8'h00, 64'h0);
        rst = 1'b1;
        mid();
        chk1("rstmid_bank1_waking", awake[1], 1'b0);
        nxt();
        rst = 1'b0;
        clear_inputs();
        mid();
        chk("rstmid_awake_all", DW'(awake), DW'({NB{1'b1}}));
        chk("rstmid_no_rvalid", DW'(rvalid), 64'h0);
        chk1("rstmid_rdata_zero", |rdata_v, 1'b0);
        nxt();
        drv(0, 1'b1, 1'b0, 6'd5, 8'h00, 64'h0);
        mid();
        chk1("rstmid_no_late_rvalid", rvalid[0], 1'b0);
        nxt();
        clear_inputs();
        nxt();
        mid();
        chk1("rst_keeps_sram_rvalid", rvalid[0], 1'b1);
        chk("rst_keeps_sram_rdata", rdata_v[DW-1:0], 64'hDEADBEEF_01234567);
        nxt();

        // All banks with random traffic against the reference model
        rst = 1'b1;
        clear_inputs();
        nxt();
        rst = 1'b0;
        for (int b = 0; b < NB; b++) begin
            exp_v[b] = '0; exp_d0[b] = '0; exp_d1[b] = '0;
        end
        for (int k = 0; k < 8; k++) rnd_cycle(0, k);
        for (int k = 0; k < 200; k++) rnd_cycle(1, k);
        for (int k = 0; k < 3; k++) rnd_cycle(2, k);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
